// File: rtl/array_2d_scanner.sv
// Row-major scanner over a WA x WC register array with a valid/ready output stream.
// Elements are captured into output registers when loaded, so later writes never disturb a presented beat.
module array_2d_scanner #(
  parameter int WA = 8,
  parameter int WC = 8,
  parameter int WB = 8,
  localparam int RW = (WA > 1) ? $clog2(WA) : 1,
  localparam int CW = (WC > 1) ? $clog2(WC) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [WB-1:0] wr_dat,
  input  logic          scan_start,
  output logic          scan_busy,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [WB-1:0] out_dat,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_eol,
  output logic          out_eof
);
  // Handshake: a beat moves when out_vld && out_rdy; all out_* hold while out_vld && !out_rdy.

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(WA - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WC - 1);
  localparam logic [RW:0]   ROW_LIM  = (RW + 1)'(WA);
  localparam logic [CW:0]   COL_LIM  = (CW + 1)'(WC);

  logic [WB-1:0] mem [WA][WC];

  state_t        state_q;
  state_t        state_d;
  logic          load;
  logic [RW-1:0] ld_row;
  logic [CW-1:0] ld_col;
  logic [WB-1:0] ld_dat;
  logic          wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_row][wr_col] <= wr_dat;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ld_row  = out_row;
    ld_col  = out_col;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          load    = 1'b1;
          ld_row  = '0;
          ld_col  = '0;
        end
      end
      SCAN: begin
        if (out_rdy) begin
          if (out_eof) begin
            state_d = IDLE;
          end else begin
            load = 1'b1;
            if (out_col == COL_LAST) begin
              ld_col = '0;
              ld_row = out_row + RW'(1);
            end else begin
              ld_col = out_col + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing on the element being loaded this edge wins over the stale array word.
  always_comb begin
    ld_dat = mem[ld_row][ld_col];
    if (wr_ok && (wr_row == ld_row) && (wr_col == ld_col)) begin
      ld_dat = wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_dat <= '0;
      out_row <= '0;
      out_col <= '0;
      out_eol <= 1'b0;
      out_eof <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_dat <= ld_dat;
        out_row <= ld_row;
        out_col <= ld_col;
        out_eol <= (ld_col == COL_LAST);
        out_eof <= (ld_row == ROW_LAST) && (ld_col == COL_LAST);
      end
    end
  end

  assign scan_busy = (state_q == SCAN);
  assign out_vld   = scan_busy;

endmodule

// File: tb/tb_array_2d_scanner.sv
// Bench for array_2d_scanner: an 8x8 instance for the main scans and a 5x3 instance for odd sizes.
module tb_array_2d_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr_en, scan_start, out_rdy;
  logic [2:0] wr_row, wr_col;
  logic [7:0] wr_dat;
  logic       scan_busy, out_vld, out_eol, out_eof;
  logic [7:0] out_dat;
  logic [2:0] out_row, out_col;

  logic       s_wr_en, s_scan_start, s_out_rdy;
  logic [2:0] s_wr_row;
  logic [1:0] s_wr_col;
  logic [7:0] s_wr_dat;
  logic       s_scan_busy, s_out_vld, s_out_eol, s_out_eof;
  logic [7:0] s_out_dat;
  logic [2:0] s_out_row;
  logic [1:0] s_out_col;

  array_2d_scanner #(.WA(8), .WC(8), .WB(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_dat(wr_dat), .scan_start(scan_start), .scan_busy(scan_busy), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_dat(out_dat), .out_row(out_row), .out_col(out_col),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  array_2d_scanner #(.WA(5), .WC(3), .WB(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_row(s_wr_row), .wr_col(s_wr_col),
    .wr_dat(s_wr_dat), .scan_start(s_scan_start), .scan_busy(s_scan_busy), .out_vld(s_out_vld),
    .out_rdy(s_out_rdy), .out_dat(s_out_dat), .out_row(s_out_row), .out_col(s_out_col),
    .out_eol(s_out_eol), .out_eof(s_out_eof)
  );

  logic [15:0] exp_q[$];
  logic [15:0] s_exp_q[$];
  logic [7:0]  model [8][8];
  logic [7:0]  s_model [5][3];
  int n_checks = 0;
  int n_errors = 0;
  int vld_cycles = 0;
  int s_beats = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack_big(input logic [7:0] d, input int r, input int c);
    return {d, 3'(r), 3'(c), (c == 7), (r == 7 && c == 7)};
  endfunction

  function automatic logic [15:0] pack_small(input logic [7:0] d, input int r, input int c);
    return {d, 3'(r), 1'b0, 2'(c), (c == 2), (r == 4 && c == 2)};
  endfunction

  // Scoreboards: pop on every transfer, plus hold checks across stalled cycles.
  always @(negedge clk) begin
    logic [15:0] now;
    now = {out_dat, out_row, out_col, out_eol, out_eof};
    if (out_vld) vld_cycles++;
    if (stall_prev) check("stall_hold", now, held);
    stall_prev = out_vld && !out_rdy;
    held = now;
    if (out_vld && out_rdy) begin
      if (exp_q.size() == 0) check("unexpected_beat", now, 16'hFFFF);
      else check("beat", now, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [15:0] now;
    now = {s_out_dat, s_out_row, 1'b0, s_out_col, s_out_eol, s_out_eof};
    if (s_out_vld && s_out_rdy) begin
      s_beats++;
      if (s_exp_q.size() == 0) check("s_unexpected_beat", now, 16'hFFFF);
      else check("s_beat", now, s_exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_big(input int r, input int c, input logic [7:0] d);
    wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_dat = d;
    tick();
    wr_en = 1'b0;
    model[r][c] = d;
  endtask

  task automatic start_scan();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back(pack_big(model[r][c], r, c));
    vld_cycles = 0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("start_vld", out_vld, 1);
    check("start_pos", {out_row, out_col}, 0);
  endtask

  task automatic drain(input bit toggle, input int exp_cycles);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      if (toggle) out_rdy = ~out_rdy;
      tick();
    end
    check("drained", exp_q.size(), 0);
    check("busy_after", scan_busy, 0);
    check("vld_after", out_vld, 0);
    check("scan_cycles", vld_cycles, exp_cycles);
    exp_q.delete();
    out_rdy = 1'b1;
  endtask

  task automatic wait_at(input int r, input int c);
    for (int i = 0; i < 200 && !(out_vld && out_row == 3'(r) && out_col == 3'(c)); i++) tick();
    check("reach_pos", {out_vld, out_row, out_col}, {1'b1, 3'(r), 3'(c)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_row = 0; wr_col = 0; wr_dat = 0; scan_start = 0; out_rdy = 1'b1;
    s_wr_en = 0; s_wr_row = 0; s_wr_col = 0; s_wr_dat = 0; s_scan_start = 0; s_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", out_vld, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_dat", out_dat, 0);
    check("rst_pos", {out_row, out_col}, 0);
    check("rst_eol_eof", {out_eol, out_eof}, 0);
    check("rst_s_vld", s_out_vld, 0);
    rst_n = 1'b1;
    tick();

    // Full fill, continuous ready.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        wr_big(r, c, 8'(r * 16 + c));
    start_scan();
    drain(1'b0, 64);

    // Ready toggling, first presented cycle stalled.
    out_rdy = 1'b1;
    start_scan();
    drain(1'b1, 128);

    // Writes while stalled on [2][3]: presented beat unchanged, later beat updated.
    model[5][0] = 8'hBB;
    start_scan();
    wait_at(2, 3);
    out_rdy = 1'b0;
    wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd3; wr_dat = 8'hAA;
    tick();
    wr_row = 3'd5; wr_col = 3'd0; wr_dat = 8'hBB;
    tick();
    wr_en = 1'b0;
    check("hold_23", out_dat, 8'h23);
    out_rdy = 1'b1;
    drain(1'b0, 66);
    model[2][3] = 8'hAA;

    // Reset while presenting [4][4], then rescan from [0][0] with memory intact.
    start_scan();
    wait_at(4, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_vld, 0);
    check("mid_rst_busy", scan_busy, 0);
    check("mid_rst_outs", {out_dat, out_row, out_col, out_eol, out_eof}, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_scan();
    check("restart_dat", out_dat, 8'h00);
    drain(1'b0, 64);

    // 5x3 instance: out-of-range writes, 15 beats, scan_start ignored mid-scan.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 3; c++) begin
        s_wr_en = 1'b1; s_wr_row = 3'(r); s_wr_col = 2'(c); s_wr_dat = 8'(r * 16 + c + $urandom_range(0, 1) * 8);
        s_model[r][c] = s_wr_dat;
        tick();
      end
    s_wr_row = 3'd6; s_wr_col = 2'd0; s_wr_dat = 8'hEE;
    tick();
    s_wr_row = 3'd1; s_wr_col = 2'd3;
    tick();
    s_wr_en = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 3; c++)
        s_exp_q.push_back(pack_small(s_model[r][c], r, c));
    s_beats = 0;
    s_scan_start = 1'b1;
    tick();
    s_scan_start = 1'b0;
    check("s_start_vld", s_out_vld, 1);
    for (int i = 0; i < 100 && s_exp_q.size() != 0; i++) begin
      s_scan_start = (i == 4);
      tick();
    end
    s_scan_start = 1'b0;
    check("s_drained", s_exp_q.size(), 0);
    check("s_busy_after", s_scan_busy, 0);
    check("s_beat_count", s_beats, 15);
    repeat (4) tick();
    check("s_no_restart_beats", s_beats, 15);
    check("s_no_restart_busy", s_scan_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
